regfile_scan_checker: RTL and testbench

Synthesizable run-and-verify controller for processor bring-up. It lets the CPU run for a programmable cycle budget and counts architectural register writes. It then takes over one regfile read port and sweeps every register against an expected-value source, reporting pass/fail, an error count and the first failing register. It sits between the CPU's `rs1` output and the regfile `ctrl_readRegA` input, with a configurable read latency so it fits both combinational and registered regfiles.

---
 rtl/scan_chk_pkg.sv | 22 ++
 rtl/scan_chk_delay.sv | 45 ++++
 rtl/regfile_scan_checker.sv | 230 +++++++++++++++++++++++
 tb/tb_regfile_scan_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chk_pkg.sv
// Shared types and sizing helpers for the regfile run-and-verify controller.
package scan_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

    localparam int READ_LAT_MAX = 2;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scan_chk_delay.sv
// Valid+index delay line that lines up a scan index with the data it addressed.
// DEPTH=0 is a pure pass-through; depths above READ_LAT_MAX are clamped.
module scan_chk_delay
    import scan_chk_pkg::*;
#(
    parameter int DEPTH = 0,
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int TAP     = (DEPTH > READ_LAT_MAX) ? READ_LAT_MAX : DEPTH;
    localparam int TAP_IDX = (TAP == 0) ? 0 : TAP - 1;

    logic [IDX_W:0] stg_q [READ_LAT_MAX];

    // Shift register of {valid, index}; reset discards in-flight compares.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT_MAX; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[0] <= {valid_i, idx_i};
            for (int i = 1; i < READ_LAT_MAX; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    // Output tap selection.
    always_comb begin
        if (TAP == 0) begin
            {valid_o, idx_o} = {valid_i, idx_i};
        end else begin
            {valid_o, idx_o} = stg_q[TAP_IDX];
        end
    end

endmodule

// File: rtl/regfile_scan_checker.sv
// Run-and-verify controller: runs the CPU for a cycle budget, then sweeps the regfile
// through read port A against an expected-value source. Option macro: SCAN_CHK_FIRST_FAIL_EN.
module regfile_scan_checker
    import scan_chk_pkg::*;
#(
    parameter int  NUM_REGS = 32,
    parameter int  DATA_W   = 32,
    parameter int  CYC_W    = 16,
    parameter int  READ_LAT = 0,
    localparam int ADDR_W   = addr_w(NUM_REGS),
    localparam int ERR_W    = cnt_w(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic              rwe,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1_cpu,
    output logic [ADDR_W-1:0] rs1_out,
    input  logic [DATA_W-1:0] reg_data,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              test_mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CYC_W-1:0]  write_count,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_exp,
    output logic [DATA_W-1:0] first_fail_act
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(NUM_REGS);
    localparam logic [CYC_W-1:0]  CYC_MAX  = {CYC_W{1'b1}};

    scan_state_e       state_q, state_d;
    logic [CYC_W-1:0]  budget_q, budget_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CYC_W-1:0]  wr_q, wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic              scan_s;
    logic              test_mode_s;
    logic              accept_start_s;
    logic              cmp_valid_s;
    logic [ADDR_W-1:0] cmp_idx_s;
    logic              mismatch_s;

    assign scan_s         = (state_q == ST_SCAN);
    assign test_mode_s    = scan_s || (state_q == ST_DRAIN);
    assign accept_start_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch_s     = cmp_valid_s && (reg_data != exp_data);

    scan_chk_delay #(
        .DEPTH (READ_LAT),
        .IDX_W (ADDR_W)
    ) u_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (scan_s),
        .idx_i   (idx_q),
        .valid_o (cmp_valid_s),
        .idx_o   (cmp_idx_s)
    );

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        budget_d = budget_q;
        cyc_d    = cyc_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        if (mismatch_s && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    budget_d = num_cycles;
                    cyc_d    = CYC_W'(0);
                    wr_d     = CYC_W'(0);
                    err_d    = ERR_W'(0);
                    idx_d    = ADDR_W'(0);
                    if (num_cycles == CYC_W'(0)) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (cyc_q != CYC_MAX) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end else begin
                    cyc_d = cyc_q;
                end
                // x0 is hard-wired, so writes to it are not architectural.
                if (rwe && (rd != ADDR_W'(0)) && (wr_q != CYC_MAX)) begin
                    wr_d = wr_q + CYC_W'(1);
                end else begin
                    wr_d = wr_q;
                end
                if (cyc_q == (budget_q - CYC_W'(1))) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    if (READ_LAT > 0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                // Leave once the last register's compare has come out of the pipe.
                if (cmp_valid_s && (cmp_idx_s == LAST_IDX)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            budget_q <= CYC_W'(0);
            cyc_q    <= CYC_W'(0);
            wr_q     <= CYC_W'(0);
            idx_q    <= ADDR_W'(0);
            err_q    <= ERR_W'(0);
        end else begin
            state_q  <= state_d;
            budget_q <= budget_d;
            cyc_q    <= cyc_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign rs1_out     = test_mode_s ? idx_q : rs1_cpu;
    assign exp_addr    = test_mode_s ? idx_q : ADDR_W'(0);
    assign test_mode   = test_mode_s;
    assign busy        = (state_q == ST_RUN) || test_mode_s;
    assign done        = (state_q == ST_DONE);
    assign pass        = done && (err_q == ERR_W'(0));
    assign cycle_count = cyc_q;
    assign write_count = wr_q;
    assign err_count   = err_q;

`ifdef SCAN_CHK_FIRST_FAIL_EN
    logic              ff_valid_q, ff_valid_d;
    logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
    logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
    logic [DATA_W-1:0] ff_act_q, ff_act_d;

    // First-mismatch capture; sticky until the next accepted start.
    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_addr_d  = ff_addr_q;
        ff_exp_d   = ff_exp_q;
        ff_act_d   = ff_act_q;
        if (accept_start_s) begin
            ff_valid_d = 1'b0;
            ff_addr_d  = ADDR_W'(0);
            ff_exp_d   = DATA_W'(0);
            ff_act_d   = DATA_W'(0);
        end else if (mismatch_s && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_addr_d  = cmp_idx_s;
            ff_exp_d   = exp_data;
            ff_act_d   = reg_data;
        end else begin
            ff_valid_d = ff_valid_q;
        end
    end

    // First-mismatch capture registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ff_valid_q <= 1'b0;
            ff_addr_q  <= ADDR_W'(0);
            ff_exp_q   <= DATA_W'(0);
            ff_act_q   <= DATA_W'(0);
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_addr_q  <= ff_addr_d;
            ff_exp_q   <= ff_exp_d;
            ff_act_q   <= ff_act_d;
        end
    end

    assign first_fail_valid = ff_valid_q;
    assign first_fail_addr  = ff_addr_q;
    assign first_fail_exp   = ff_exp_q;
    assign first_fail_act   = ff_act_q;
`else
    logic unused_accept_s;
    assign unused_accept_s  = accept_start_s;
    assign first_fail_valid = 1'b0;
    assign first_fail_addr  = ADDR_W'(0);
    assign first_fail_exp   = DATA_W'(0);
    assign first_fail_act   = DATA_W'(0);
`endif

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Bench for regfile_scan_checker: three instances (READ_LAT 0/2/1, the last with CYC_W=4)
// share stimulus; expected values come from a register-array model of the sweep.
module tb_regfile_scan_checker;

    localparam int NR = 32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] num_cycles;
    logic        rwe;
    logic [4:0]  rd;
    logic [4:0]  rs1_cpu;

    logic [4:0]  rs1o  [3];
    logic [4:0]  eaddr [3];
    logic [31:0] rdat  [3];
    logic [31:0] edat  [3];
    logic        tm [3], bsy [3], dn [3], ps [3], ffv [3];
    logic [5:0]  ec  [3];
    logic [4:0]  ffa [3];
    logic [31:0] ffe [3], ffx [3];
    logic [15:0] cc0, cc1, wc0, wc1;
    logic [3:0]  cc_c, wc_c;

    logic [31:0] rf [NR];
    logic [31:0] ex [NR];
    logic [31:0] rp1, rp2, ep1, ep2, rq1, eq1;

    int checks   = 0;
    int failures = 0;
    int lat  [3] = '{0, 2, 1};
    int wmax [3] = '{65535, 65535, 15};

    always #5 clock = ~clock;

    // Regfile/expected-source models with 0, 2 and 1 cycles of read latency.
    always @(posedge clock) begin
        rp1 <= rf[rs1o[1]];
        rp2 <= rp1;
        ep1 <= ex[eaddr[1]];
        ep2 <= ep1;
        rq1 <= rf[rs1o[2]];
        eq1 <= ex[eaddr[2]];
    end

    assign rdat[0] = rf[rs1o[0]];
    assign edat[0] = ex[eaddr[0]];
    assign rdat[1] = rp2;
    assign edat[1] = ep2;
    assign rdat[2] = rq1;
    assign edat[2] = eq1;

    regfile_scan_checker #(.NUM_REGS(32), .DATA_W(32), .CYC_W(16), .READ_LAT(0)) dut_l0 (
        .clock(clock), .reset_n(reset_n), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .rs1_cpu(rs1_cpu), .rs1_out(rs1o[0]), .reg_data(rdat[0]),
        .exp_addr(eaddr[0]), .exp_data(edat[0]), .test_mode(tm[0]), .busy(bsy[0]),
        .done(dn[0]), .pass(ps[0]), .cycle_count(cc0), .write_count(wc0), .err_count(ec[0]),
        .first_fail_valid(ffv[0]), .first_fail_addr(ffa[0]), .first_fail_exp(ffe[0]),
        .first_fail_act(ffx[0]));

    regfile_scan_checker #(.NUM_REGS(32), .DATA_W(32), .CYC_W(16), .READ_LAT(2)) dut_l2 (
        .clock(clock), .reset_n(reset_n), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .rs1_cpu(rs1_cpu), .rs1_out(rs1o[1]), .reg_data(rdat[1]),
        .exp_addr(eaddr[1]), .exp_data(edat[1]), .test_mode(tm[1]), .busy(bsy[1]),
        .done(dn[1]), .pass(ps[1]), .cycle_count(cc1), .write_count(wc1), .err_count(ec[1]),
        .first_fail_valid(ffv[1]), .first_fail_addr(ffa[1]), .first_fail_exp(ffe[1]),
        .first_fail_act(ffx[1]));

    regfile_scan_checker #(.NUM_REGS(32), .DATA_W(32), .CYC_W(4), .READ_LAT(1)) dut_c4 (
        .clock(clock), .reset_n(reset_n), .start(start), .num_cycles(num_cycles[3:0]),
        .rwe(rwe), .rd(rd), .rs1_cpu(rs1_cpu), .rs1_out(rs1o[2]), .reg_data(rdat[2]),
        .exp_addr(eaddr[2]), .exp_data(edat[2]), .test_mode(tm[2]), .busy(bsy[2]),
        .done(dn[2]), .pass(ps[2]), .cycle_count(cc_c), .write_count(wc_c), .err_count(ec[2]),
        .first_fail_valid(ffv[2]), .first_fail_addr(ffa[2]), .first_fail_exp(ffe[2]),
        .first_fail_act(ffx[2]));

    function automatic int ccount(input int k);
        if (k == 0) return int'(cc0);
        else if (k == 1) return int'(cc1);
        else return int'(cc_c);
    endfunction

    function automatic int wcount(input int k);
        if (k == 0) return int'(wc0);
        else if (k == 1) return int'(wc1);
        else return int'(wc_c);
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s dut%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_matching();
        for (int i = 0; i < NR; i++) begin
            rf[i] = $urandom;
            ex[i] = rf[i];
        end
    endtask

    task automatic do_run(input int n, input bit all_w, input int glitch_t);
        int w, e, ff, endt;
        w  = 0;
        e  = 0;
        ff = -1;
        for (int i = 0; i < NR; i++) begin
            if (rf[i] != ex[i]) begin
                e++;
                if (ff < 0) ff = i;
            end
        end
        num_cycles = 16'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        for (int t = 0; t <= n + 36; t++) begin
            for (int k = 0; k < 3; k++) begin
                endt = n + NR + lat[k];
                chk("test_mode", k, tm[k], (t >= n) && (t < endt));
                chk("busy", k, bsy[k], t < endt);
                chk("done", k, dn[k], t >= endt);
            end
            rwe     = all_w ? 1'b1 : 1'($urandom_range(0, 1));
            rd      = all_w ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
            rs1_cpu = 5'($urandom);
            start   = (t == glitch_t);
            if ((t < n) && rwe && (rd != 5'd0)) w++;
            #1;
            for (int k = 0; k < 3; k++) begin
                if ((t >= n) && (t < n + NR)) begin
                    chk("rs1_out_scan", k, rs1o[k], t - n);
                    chk("exp_addr", k, eaddr[k], t - n);
                end else if (!((t >= n) && (t < n + NR + lat[k]))) begin
                    chk("rs1_out_cpu", k, rs1o[k], rs1_cpu);
                end
            end
            tick();
            start = 1'b0;
        end
        rwe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("cycle_count", k, ccount(k), n);
            chk("write_count", k, wcount(k), (w > wmax[k]) ? wmax[k] : w);
            chk("err_count", k, ec[k], e);
            chk("pass", k, ps[k], e == 0);
            chk("done_hold", k, dn[k], 1'b1);
`ifdef SCAN_CHK_FIRST_FAIL_EN
            chk("ff_valid", k, ffv[k], e > 0);
            if (e > 0) begin
                chk("ff_addr", k, ffa[k], ff);
                chk("ff_exp", k, ffe[k], ex[ff]);
                chk("ff_act", k, ffx[k], rf[ff]);
            end
`else
            chk("ff_tied", k, {ffv[k], ffa[k], ffe[k], ffx[k]}, 64'd0);
`endif
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        num_cycles = 16'd0;
        rwe        = 1'b0;
        rd         = 5'd0;
        rs1_cpu    = 5'd9;
        load_matching();
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_flags", k, {tm[k], bsy[k], dn[k], ps[k], ffv[k]}, 64'd0);
            chk("rst_counts", k, {ec[k], 16'(ccount(k)), 16'(wcount(k))}, 64'd0);
            chk("rst_exp_addr", k, eaddr[k], 5'd0);
            chk("rst_rs1_out", k, rs1o[k], rs1_cpu);
        end
        reset_n = 1'b1;
        tick();

        // All registers match, 10-cycle budget.
        load_matching();
        do_run(10, 1'b0, -1);

        // Single mismatch at r5.
        load_matching();
        ex[5] = 32'd7;
        rf[5] = 32'd9;
        do_run($urandom_range(1, 15), 1'b0, -1);

        // Mismatches at both ends, zero budget, start ignored mid-scan.
        load_matching();
        ex[0]  = rf[0] ^ 32'h1;
        ex[31] = rf[31] + 32'd5;
        do_run(0, 1'b0, 5);

        // Full 4-bit budget, continuous writes, random mismatches, late start glitch.
        load_matching();
        for (int j = 0; j < 3; j++) begin
            int p;
            p = $urandom_range(0, NR - 1);
            ex[p] = rf[p] + 32'd1;
        end
        do_run(15, 1'b1, 15 + 20);

        // Reset asserted in the middle of a scan.
        load_matching();
        num_cycles = 16'd3;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        repeat (13) tick();
        for (int k = 0; k < 3; k++) chk("pre_rst_test_mode", k, tm[k], 1'b1);
        rs1_cpu = 5'd17;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("midrst_flags", k, {tm[k], bsy[k], dn[k]}, 3'b000);
            chk("midrst_rs1_out", k, rs1o[k], 5'd17);
            chk("midrst_cycle", k, ccount(k), 0);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();

        // Recovery run with random mismatches and budget.
        load_matching();
        for (int j = 0; j < 2; j++) begin
            int p;
            p = $urandom_range(0, NR - 1);
            rf[p] = ~ex[p];
        end
        do_run($urandom_range(1, 15), 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
